// File: rtl/ssd1306_pkg.sv
// Shared constants for the SSD1306 frame sequencer: command ROMs, control bytes,
// FSM state types and ROM lookup helpers.
package ssd1306_pkg;

   localparam int INIT_LEN = 25;
   localparam int WIN_LEN  = 6;

   localparam logic [7:0] CTRL_CMD  = 8'h00;
   localparam logic [7:0] CTRL_DATA = 8'h40;

   localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
      8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
      8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };

   localparam logic [7:0] WIN_CMDS [WIN_LEN] = '{
      8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
   };

   typedef enum logic [2:0] {
      ST_INIT_TX = 3'd0,
      ST_IDLE    = 3'd1,
      ST_WIN_TX  = 3'd2,
      ST_FB_TX   = 3'd3,
      ST_DONE    = 3'd4
   } top_state_t;

   typedef enum logic [1:0] {
      FD_IDLE = 2'd0,
      FD_SEND = 2'd1,
      FD_WAIT = 2'd2
   } feed_state_t;

   // Out-of-range indices return 0x00; callers only ask for valid payload slots.
   function automatic logic [7:0] init_byte(input logic [10:0] idx);
      init_byte = 8'h00;
      for (int k = 0; k < INIT_LEN; k++)
         if (idx == 11'(k)) init_byte = INIT_CMDS[k];
   endfunction

   function automatic logic [7:0] win_byte(input logic [10:0] idx);
      win_byte = 8'h00;
      for (int k = 0; k < WIN_LEN; k++)
         if (idx == 11'(k)) win_byte = WIN_CMDS[k];
   endfunction

endpackage

// File: rtl/ssd1306_tx_feeder.sv
// Generic I2C-master transaction feeder: start pulse, one strobe per data request
// via an armed flag, stop on the last byte, completion once the master goes idle.
module ssd1306_tx_feeder
   import ssd1306_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_go,
   input  logic [10:0] i_byte_count,
   input  logic [7:0]  i_byte,
   input  logic        i_m_data_req,
   input  logic        i_m_busy,
   output logic [10:0] o_byte_idx,
   output logic        o_start_fire,
   output logic        o_byte_fire,
   output logic        o_done,
   output feed_state_t o_state,
   output logic        o_m_start,
   output logic        o_m_stop,
   output logic        o_m_data_valid,
   output logic [7:0]  o_m_data_in
);

   // Handshake: a byte is strobed when r_armed && i_m_data_req; the strobe clears
   // r_armed, which only re-arms after i_m_data_req is seen low, so a registered
   // request that lingers high yields exactly one o_m_data_valid per request.
   feed_state_t r_state, w_next;
   logic [10:0] r_idx;
   logic        r_armed;
   logic        r_m_start, r_m_stop, r_m_valid;
   logic [7:0]  r_m_data;
   logic        w_start_fire, w_byte_fire, w_last, w_done;

   always_comb begin
      w_next       = r_state;
      w_start_fire = 1'b0;
      w_byte_fire  = 1'b0;
      w_done       = 1'b0;
      w_last       = (r_idx == (i_byte_count - 11'd1));
      case (r_state)
         FD_IDLE: if (i_go && !i_m_busy) begin
            w_start_fire = 1'b1;
            w_next       = FD_SEND;
         end
         FD_SEND: if (r_armed && i_m_data_req) begin
            w_byte_fire = 1'b1;
            if (w_last) w_next = FD_WAIT;
         end
         FD_WAIT: if (!i_m_busy) begin
            w_done = 1'b1;
            w_next = FD_IDLE;
         end
         default: w_next = FD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FD_IDLE;
         r_idx     <= 11'd0;
         r_armed   <= 1'b1;
         r_m_start <= 1'b0;
         r_m_stop  <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_data  <= 8'h00;
      end else begin
         r_state   <= w_next;
         r_m_start <= w_start_fire;
         r_m_valid <= w_byte_fire;
         r_m_stop  <= w_byte_fire && w_last;
         if (w_start_fire)     r_idx <= 11'd0;
         else if (w_byte_fire) r_idx <= r_idx + 11'd1;
         if (w_byte_fire) begin
            r_m_data <= i_byte;
            r_armed  <= 1'b0;
         end else if (!r_armed && !i_m_data_req) begin
            r_armed  <= 1'b1;
         end
      end
   end

   assign o_byte_idx     = r_idx;
   assign o_start_fire   = w_start_fire;
   assign o_byte_fire    = w_byte_fire;
   assign o_done         = w_done;
   assign o_state        = r_state;
   assign o_m_start      = r_m_start;
   assign o_m_stop       = r_m_stop;
   assign o_m_data_valid = r_m_valid;
   assign o_m_data_in    = r_m_data;

endmodule

// File: rtl/ssd1306_frame_sequencer.sv
// SSD1306 frame sequencer: init transaction, then window + framebuffer transactions
// per refresh. Define SSD1306_CONT_REFRESH_EN for continuous back-to-back frames.
module ssd1306_frame_sequencer
   import ssd1306_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = 7'h3C,
   parameter int         FB_BYTES = 1024
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        refresh,
   output logic        ready,
   output logic        frame_done,
   output logic        seq_busy,
   output logic [9:0]  fb_addr,
   input  logic [7:0]  fb_data,
   output logic        m_start,
   output logic        m_stop,
   output logic        m_data_valid,
   output logic [7:0]  m_data_in,
   input  logic        m_data_req,
   input  logic        m_busy,
   output top_state_t  dbg_state,
   output feed_state_t dbg_feed_state
);

   localparam logic [10:0] INIT_TX_LEN = 11'(INIT_LEN + 2);
   localparam logic [10:0] WIN_TX_LEN  = 11'(WIN_LEN + 2);
   localparam logic [10:0] FB_TX_LEN   = 11'(FB_BYTES + 2);
   localparam logic [9:0]  LAST_ADDR   = 10'(FB_BYTES - 1);

   top_state_t  r_state, w_next;
   logic        r_pending, r_ready, r_tx_started;
   logic [9:0]  r_fb_addr;
   logic        w_go, w_start_fire, w_byte_fire, w_done;
   logic [10:0] w_count, w_idx, w_pl_idx;
   logic [7:0]  w_ctrl, w_payload, w_byte;

   assign w_pl_idx = w_idx - 11'd2;

   always_comb begin
      w_next    = r_state;
      w_go      = 1'b0;
      w_count   = 11'd0;
      w_ctrl    = CTRL_CMD;
      w_payload = 8'h00;
      case (r_state)
         ST_INIT_TX: begin
            w_go      = !r_tx_started;
            w_count   = INIT_TX_LEN;
            w_payload = init_byte(w_pl_idx);
            if (w_done) w_next = ST_IDLE;
         end
         ST_IDLE: if (r_pending) w_next = ST_WIN_TX;
         ST_WIN_TX: begin
            w_go      = !r_tx_started;
            w_count   = WIN_TX_LEN;
            w_payload = win_byte(w_pl_idx);
            if (w_done) w_next = ST_FB_TX;
         end
         ST_FB_TX: begin
            w_go      = !r_tx_started;
            w_count   = FB_TX_LEN;
            w_ctrl    = CTRL_DATA;
            w_payload = fb_data;
            if (w_done) w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_INIT_TX;
      endcase
      if (w_idx == 11'd0)      w_byte = {I2C_ADDR, 1'b0};
      else if (w_idx == 11'd1) w_byte = w_ctrl;
      else                     w_byte = w_payload;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_INIT_TX;
         r_pending    <= 1'b0;
         r_ready      <= 1'b0;
         r_tx_started <= 1'b0;
         r_fb_addr    <= 10'd0;
      end else begin
         r_state <= w_next;
         if (w_done)            r_tx_started <= 1'b0;
         else if (w_start_fire) r_tx_started <= 1'b1;
         if (r_state == ST_INIT_TX && w_done) r_ready <= 1'b1;
         if (refresh) r_pending <= 1'b1;
`ifdef SSD1306_CONT_REFRESH_EN
         else if (r_state == ST_DONE || (r_state == ST_INIT_TX && w_done)) r_pending <= 1'b1;
`endif
         else if (r_state == ST_IDLE) r_pending <= 1'b0;
         // fb_addr leads the strobe by a request cycle so fb_data is settled when sampled.
         if (r_state != ST_FB_TX && w_next == ST_FB_TX)
            r_fb_addr <= 10'd0;
         else if (r_state == ST_FB_TX && w_byte_fire && w_idx >= 11'd2 && r_fb_addr != LAST_ADDR)
            r_fb_addr <= r_fb_addr + 10'd1;
      end
   end

   ssd1306_tx_feeder u_feeder (
      .clk            (clk),
      .rst            (rst),
      .i_go           (w_go),
      .i_byte_count   (w_count),
      .i_byte         (w_byte),
      .i_m_data_req   (m_data_req),
      .i_m_busy       (m_busy),
      .o_byte_idx     (w_idx),
      .o_start_fire   (w_start_fire),
      .o_byte_fire    (w_byte_fire),
      .o_done         (w_done),
      .o_state        (dbg_feed_state),
      .o_m_start      (m_start),
      .o_m_stop       (m_stop),
      .o_m_data_valid (m_data_valid),
      .o_m_data_in    (m_data_in)
   );

   assign ready      = r_ready;
   assign frame_done = (r_state == ST_DONE);
   assign seq_busy   = (r_state != ST_IDLE) | r_pending;
   assign fb_addr    = r_fb_addr;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_ssd1306_frame_sequencer.sv
// Directed/random bench for ssd1306_frame_sequencer: behavioural I2C master and
// framebuffer RAM, expected byte stream built from the panel command lists.
module tb_ssd1306_frame_sequencer;
   import ssd1306_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        refresh = 1'b0;
   logic        ready, frame_done, seq_busy;
   logic [9:0]  fb_addr;
   logic [7:0]  fb_data = 8'h00;
   logic        m_start, m_stop, m_data_valid;
   logic [7:0]  m_data_in;
   logic        m_data_req = 1'b0;
   logic        m_busy = 1'b0;
   top_state_t  dbg_state;
   feed_state_t dbg_feed_state;

   localparam logic [7:0] INIT_REF [25] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
      8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
      8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };
   localparam logic [7:0] WIN_REF [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

   logic [7:0] mem [1024];
   logic [8:0] exp_q[$];
   int         exp_len_q[$];
   int         n_tests = 0, n_fail = 0;
   int         n_frames = 0, n_starts = 0, txn_len = 0, strobes_this_req = 0;
   int         hold = 0, gap = 0, tail = 0, starts0 = 0;
   logic       stop_seen = 1'b0, prev_fd = 1'b0, prev_ready = 1'b0;
   logic [7:0] txn_ctrl = 8'h00;
   logic [9:0] last_addr = 10'd0;
   logic [8:0] exp_b;

   ssd1306_frame_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .refresh        (refresh),
      .ready          (ready),
      .frame_done     (frame_done),
      .seq_busy       (seq_busy),
      .fb_addr        (fb_addr),
      .fb_data        (fb_data),
      .m_start        (m_start),
      .m_stop         (m_stop),
      .m_data_valid   (m_data_valid),
      .m_data_in      (m_data_in),
      .m_data_req     (m_data_req),
      .m_busy         (m_busy),
      .dbg_state      (dbg_state),
      .dbg_feed_state (dbg_feed_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input logic last);
      exp_q.push_back({last, b});
   endtask

   task automatic push_init();
      push_byte(8'h78, 1'b0);
      push_byte(8'h00, 1'b0);
      for (int i = 0; i < 25; i++) push_byte(INIT_REF[i], i == 24);
      exp_len_q.push_back(27);
   endtask

   task automatic push_frame();
      push_byte(8'h78, 1'b0);
      push_byte(8'h00, 1'b0);
      for (int i = 0; i < 6; i++) push_byte(WIN_REF[i], i == 5);
      exp_len_q.push_back(8);
      push_byte(8'h78, 1'b0);
      push_byte(8'h40, 1'b0);
      for (int i = 0; i < 1024; i++) push_byte(mem[i], i == 1023);
      exp_len_q.push_back(1026);
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic observe();
      if (m_start) begin
         n_starts++;
         txn_len = 0;
         check("start_only_when_master_idle", 32'(m_busy), 0);
      end
      if (m_stop) check("stop_only_with_strobe", 32'(m_data_valid), 1);
      if (m_data_valid) begin
         check("one_strobe_per_request", strobes_this_req, 0);
         strobes_this_req++;
         if (txn_len == 1) txn_ctrl = m_data_in;
         txn_len++;
         n_tests++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_byte: observed %0h expected none", {m_stop, m_data_in});
         end
         if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("byte_stop_and_data", 32'({m_stop, m_data_in}), 32'(exp_b));
         end
         if (m_stop && exp_len_q.size() != 0) check("txn_length", txn_len, exp_len_q.pop_front());
      end
      if (frame_done) begin
         check("frame_done_single_pulse", 32'(prev_fd), 0);
         n_frames++;
      end
      prev_fd = frame_done;
      if (ready && !prev_ready) check("ready_after_busy_fall", 32'(m_busy), 0);
      prev_ready = ready;
   endtask

   task automatic master_step();
      if (rst) begin
         m_busy = 1'b0; m_data_req = 1'b0; stop_seen = 1'b0;
         hold = 0; gap = 0; tail = 0;
         return;
      end
      if (m_start) begin
         m_busy = 1'b1; stop_seen = 1'b0; gap = $urandom_range(1, 3);
      end
      if (m_data_valid && m_stop) begin
         stop_seen = 1'b1; tail = $urandom_range(1, 4);
      end
      if (m_data_req) begin
         hold--;
         if (hold == 0) begin
            check("strobes_per_request", strobes_this_req, 1);
            m_data_req = 1'b0;
            gap = $urandom_range(1, 3);
         end
      end else if (m_busy) begin
         if (stop_seen) begin
            if (tail == 0) m_busy = 1'b0;
            else tail--;
         end else if (gap > 1) begin
            gap--;
         end else begin
            m_data_req = 1'b1; hold = 5; strobes_this_req = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      fb_data   = mem[last_addr];
      last_addr = fb_addr;
      observe();
      master_step();
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      for (int i = 0; i < budget && !ready; i++) tick();
      check("ready_timeout", 32'(ready), 1);
   endtask

   task automatic wait_frames(input int target, input int budget);
      for (int i = 0; i < budget && n_frames < target; i++) tick();
      check("frame_timeout", 32'(n_frames >= target), 1);
   endtask

   initial begin
      randomize_mem();
      repeat (3) tick();
      check("rst_m_start", 32'(m_start), 0);
      check("rst_m_data_valid", 32'(m_data_valid), 0);
      check("rst_m_stop", 32'(m_stop), 0);
      check("rst_m_data_in", 32'(m_data_in), 0);
      check("rst_ready", 32'(ready), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_fb_addr", 32'(fb_addr), 0);
      check("rst_seq_busy_init_state", 32'(seq_busy), 1);

`ifdef SSD1306_CONT_REFRESH_EN
      push_init();
      push_frame();
      push_frame();
      rst = 1'b0;
      wait_ready(3000);
      wait_frames(2, 40000);
      check("cont_all_bytes_seen", exp_q.size(), 0);
      check("cont_ready", 32'(ready), 1);
      check("cont_frame_count", n_frames, 2);
`else
      // Init transaction
      push_init();
      rst = 1'b0;
      wait_ready(3000);
      check("init_all_bytes_seen", exp_q.size(), 0);
      check("init_idle_not_busy", 32'(seq_busy), 0);
      check("init_no_frame", n_frames, 0);

      // One frame on a single refresh
      randomize_mem();
      starts0 = n_starts;
      push_frame();
      pulse_refresh();
      check("refresh_sets_busy", 32'(seq_busy), 1);
      wait_frames(1, 20000);
      repeat (50) tick();
      check("frame1_all_bytes_seen", exp_q.size(), 0);
      check("frame1_count", n_frames, 1);
      check("frame1_starts", n_starts - starts0, 2);
      check("frame1_idle", 32'(seq_busy), 0);
      check("fb_addr_holds_last", 32'(fb_addr), 1023);

      // Three refresh pulses during a frame collapse to one extra frame
      randomize_mem();
      starts0 = n_starts;
      push_frame();
      push_frame();
      pulse_refresh();
      for (int p = 0; p < 3; p++) begin
         repeat ($urandom_range(100, 1500)) tick();
         pulse_refresh();
      end
      wait_frames(3, 30000);
      repeat (300) tick();
      check("collapse_all_bytes_seen", exp_q.size(), 0);
      check("collapse_frame_count", n_frames, 3);
      check("collapse_starts", n_starts - starts0, 4);
      check("collapse_idle", 32'(seq_busy), 0);

      // Reset in the middle of the framebuffer transaction
      push_frame();
      txn_len = 0;
      txn_ctrl = 8'h00;
      pulse_refresh();
      for (int i = 0; i < 20000 && !(txn_ctrl == 8'h40 && txn_len >= 302); i++) tick();
      check("reach_byte_300", 32'(txn_len), 302);
      rst = 1'b1;
      #1;
      check("midrst_m_start", 32'(m_start), 0);
      check("midrst_m_data_valid", 32'(m_data_valid), 0);
      check("midrst_m_stop", 32'(m_stop), 0);
      check("midrst_m_data_in", 32'(m_data_in), 0);
      check("midrst_ready", 32'(ready), 0);
      check("midrst_frame_done", 32'(frame_done), 0);
      check("midrst_fb_addr", 32'(fb_addr), 0);
      exp_q.delete();
      exp_len_q.delete();
      repeat (3) tick();
      prev_ready = 1'b0;
      push_init();
      rst = 1'b0;
      wait_ready(3000);
      repeat (20) tick();
      check("reinit_all_bytes_seen", exp_q.size(), 0);
      check("reinit_idle", 32'(seq_busy), 0);
      check("reinit_no_frame", n_frames, 3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
